lsu: RTL and testbench
======================

# lsu

Load/store unit between the execute stage and the 256×32 data memory (`dmem`). It accepts one byte-addressed load or store at a time and generates the word address, byte write strobes and lane-aligned write data for `dmem`. It sign- or zero-extends returned read data. Accesses that cross a 32-bit word boundary are split into two back-to-back word accesses. The unit holds `req_ready` low while busy and returns a single-cycle response to the pipeline.

## Interface
Parameters:
- none; geometry is fixed at 256 words = 1 KiB byte space, so the byte address is 10 bits.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE. A transfer occurs when `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` in 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 10: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse when the access completes. The consumer always accepts it.
- `resp_data` out 32: extended load data. 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`.
- `dmem_writeb` out 4: byte strobes to `dmem`.
- `dmem_read` out 1: read strobe to `dmem`.
- `dmem_addr` out 8: word address.
- `dmem_wdata` out 32: lane-aligned store data.
- `dmem_rdata` in 32: `dmem` read data, valid the cycle after `dmem_read`.

## Operation
- On accept, latch write, size, unsigned, address and wdata.
- Definitions:
  - `off = addr[1:0]`
  - `w = addr[9:2]`
  - `n = 1 << size` (bytes)
  - The access crosses a word boundary when `off + n > 4`.
- States: IDLE, ACC0, ACC1, CAP, ERR.
- State transitions:
  - IDLE → ACC0 on accept of a legal request.
  - IDLE → ERR on accept of an illegal request.
  - ACC0 → ACC1 if the access crosses a word.
  - ACC0 → CAP for a non-crossing load.
  - ACC0 → IDLE for a non-crossing store.
  - ACC1 → CAP for a load.
  - ACC1 → IDLE for a store.
  - CAP → IDLE.
  - ERR → IDLE.
- Byte mask: `m8 = ((1<<n)-1) << off` (8 bits).
- Store data: `wd64 = {req_wdata, req_wdata} << (8*off)`.
- ACC0 drives:
  - `dmem_addr = w`
  - `dmem_writeb = m8[3:0]`, stores only
  - `dmem_wdata = wd64[31:0]`
  - `dmem_read`, loads only
- ACC1 drives:
  - `dmem_addr = w+1` (8-bit wrap: word 255 is followed by word 0)
  - `dmem_writeb = m8[7:4]`
  - `dmem_wdata = wd64[63:32]`
- In all other states `dmem_read = 0`, `dmem_writeb = 0`, and `dmem_addr`/`dmem_wdata` hold their last values.
- Load assembly:
  - In ACC1, `dmem_rdata` holds word w; latch it as `lo`.
  - In CAP, `dmem_rdata` holds the final word: word w for a non-crossing load, word w+1 for a crossing load.
  - `r64 = {rdata, lo}` for a crossing load, `{32'b0, rdata}` otherwise.
  - Shift: `r64 >> (8*off)`.
  - Take the low `n` bytes and extend per `req_unsigned`.
  - Register the result into `resp_data`.
- Illegal request: `req_size == 3`, or a crossing access when split is disabled (see Configuration).
  - No `dmem` strobes are issued.
  - Response is `resp_err = 1`, `resp_data = 0`.
- `resp_valid`, `resp_data` and `resp_err` are registered. They are set on the edge that enters IDLE from ACC0, ACC1, CAP or ERR, and cleared on the following edge.
- Reset (asynchronous, any state) forces:
  - state = IDLE
  - `resp_valid = 0`, `resp_data = 0`, `resp_err = 0`
  - `dmem_read = 0`, `dmem_writeb = 0`, `dmem_addr = 0`, `dmem_wdata = 0`
  - `lo = 0`
- A split store interrupted by reset after ACC0 leaves word w written and word w+1 untouched. This is accepted behaviour.

## Timing
- Accept in cycle 0. `resp_valid` is high in the cycle listed:

| Access | `resp_valid` cycle |
|---|---|
| Aligned store | 2 |
| Aligned load | 3 |
| Split store | 3 |
| Split load | 4 |
| Error | 2 |

- `req_ready` is high in the same cycle as `resp_valid`. A new request may be accepted in that cycle.
- Back-to-back aligned stores therefore issue one every 2 cycles.
- `dmem` strobes are high for exactly one cycle per word access and never in two consecutive cycles to the same word.

## Configuration
- `LSU_SPLIT_EN`
  - Defined: crossing accesses are split across ACC0/ACC1 as described.
  - Undefined: ACC1 is never entered. Crossing accesses go IDLE → ERR and respond with `resp_err = 1`, no memory access, latency 2. Non-crossing behaviour is identical in both builds.

## Test plan
- Reset with `rst_n` low mid-ACC0 store.
  - All outputs go to 0 immediately and `req_ready` = 1.
  - After release, an aligned word load of 0x000 returns the memory contents.
- Store word 0xDEADBEEF at 0x004, then load signed byte at 0x007.
  - Store: `dmem_writeb` = 4'hF at `dmem_addr` = 1.
  - Load: `resp_data` = 0xFFFFFFDE, `resp_valid` in cycle 3.
- Store half 0x1234 at 0x00A, then load unsigned half at 0x00A.
  - `dmem_writeb` = 4'hC, `dmem_wdata[31:16]` = 0x1234.
  - Load returns 0x00001234.
- With `LSU_SPLIT_EN` defined, store word 0xA1B2C3D4 at 0x3FE.
  - Word 255: strobes 4'hC, data bytes 0xC3D4.
  - Word 0: strobes 4'h3, data bytes 0xA1B2.
  - Load word at 0x3FE returns 0xA1B2C3D4 in cycle 4.
- Without `LSU_SPLIT_EN`, load word at 0x001.
  - `resp_err` = 1, `resp_data` = 0, no `dmem_read` ever asserted, latency 2.
- `req_size` = 3 at 0x010.
  - `resp_err` = 1 in cycle 2, no strobes.
  - `req_valid` held high with the next request: that request is accepted in cycle 2.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: byte-addressed loads/stores onto a 256x32 word memory, word-crossing
// accesses split into two word accesses when LSU_SPLIT_EN is defined, otherwise flagged as errors.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [9:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic [3:0]  dmem_writeb_o,
    output logic        dmem_read_o,
    output logic [7:0]  dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i
);
    localparam int unsigned AW  = 10;
    localparam int unsigned WAW = 8;
    localparam int unsigned DW  = 32;

`ifdef LSU_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACC0 = 3'd1;
    localparam logic [2:0] ACC1 = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    // Access spills into the next word when offset + byte count exceeds 4.
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
        logic [2:0] n;
        n = 3'd1 << size;
        return ({1'b0, off} + n) > 3'd4;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] off, input logic [1:0] size);
        logic [2:0] n;
        n = 3'd1 << size;
        return ((8'd1 << n) - 8'd1) << off;
    endfunction

    function automatic logic [2*DW-1:0] lane_data(input logic [DW-1:0] wdata, input logic [1:0] off);
        return {wdata, wdata} << {off, 3'b000};
    endfunction

    logic [2:0]     state_q, state_d;
    logic           ready_q, ready_d;
    logic           write_q, write_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  lo_q, lo_d;
    logic           resp_valid_q, resp_valid_d;
    logic [DW-1:0]  resp_data_q, resp_data_d;
    logic           resp_err_q, resp_err_d;
    logic [3:0]     writeb_q, writeb_d;
    logic           read_q, read_d;
    logic [WAW-1:0] maddr_q, maddr_d;
    logic [DW-1:0]  mwdata_q, mwdata_d;

    logic           accept;
    logic           req_illegal;
    logic           lat_cross;
    logic [2*DW-1:0] r64;
    logic [DW-1:0]  shifted;
    logic [DW-1:0]  load_data;

    assign accept      = req_valid_i && ready_q;
    assign req_illegal = (req_size_i == 2'd3) || (crosses(req_addr_i[1:0], req_size_i) && !SplitEn);
    assign lat_cross   = crosses(addr_q[1:0], size_q);

    // Align the returned word(s) to the access offset and extend to 32 bits.
    always_comb begin
        r64     = lat_cross ? {dmem_rdata_i, lo_q} : {{DW{1'b0}}, dmem_rdata_i};
        shifted = DW'(r64 >> {addr_q[1:0], 3'b000});
        case (size_q)
            2'd0:    load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        read_d       = 1'b0;
        writeb_d     = 4'd0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (req_illegal) begin
                        state_d = ERR;
                    end else begin
                        state_d  = ACC0;
                        maddr_d  = req_addr_i[AW-1:2];
                        mwdata_d = DW'(lane_data(req_wdata_i, req_addr_i[1:0]));
                        writeb_d = req_write_i ? 4'(byte_mask(req_addr_i[1:0], req_size_i)) : 4'd0;
                        read_d   = !req_write_i;
                    end
                end
            end
            ACC0: begin
                if (lat_cross) begin
                    state_d  = ACC1;
                    maddr_d  = addr_q[AW-1:2] + WAW'(1);
                    mwdata_d = DW'(lane_data(wdata_q, addr_q[1:0]) >> DW);
                    writeb_d = write_q ? 4'(byte_mask(addr_q[1:0], size_q) >> 4) : 4'd0;
                    read_d   = !write_q;
                end else if (write_q) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = CAP;
                end
            end
            ACC1: begin
                lo_d = dmem_rdata_i;
                if (write_q) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = CAP;
                end
            end
            CAP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_data_d  = load_data;
            end
            ERR: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            writeb_q     <= 4'd0;
            read_q       <= 1'b0;
            maddr_q      <= '0;
            mwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            writeb_q     <= writeb_d;
            read_q       <= read_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
        end
    end

    assign req_ready_o   = ready_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_data_o   = resp_data_q;
    assign resp_err_o    = resp_err_q;
    assign dmem_writeb_o = writeb_q;
    assign dmem_read_o   = read_q;
    assign dmem_addr_o   = maddr_q;
    assign dmem_wdata_o  = mwdata_q;
endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed steps plus random accesses checked against a byte-array memory model.
module tb_lsu;
`ifdef LSU_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [3:0]  dmem_writeb;
    logic        dmem_read;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .resp_err_o(resp_err), .dmem_writeb_o(dmem_writeb), .dmem_read_o(dmem_read),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata)
    );

    // Word memory with one-cycle read latency and byte write strobes.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (dmem_read) dmem_rdata <= mem[dmem_addr];
        for (int b = 0; b < 4; b++)
            if (dmem_writeb[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end

    // Strobes must never hit the same word in two consecutive cycles.
    int         repeat_viol = 0;
    logic       mon_act;
    logic       prev_act = 1'b0;
    logic [7:0] prev_addr = 8'd0;
    always @(negedge clk) begin
        mon_act = dmem_read || (dmem_writeb != 4'd0);
        if (mon_act && prev_act && dmem_addr == prev_addr) repeat_viol++;
        prev_act  = mon_act;
        prev_addr = dmem_addr;
    end

    logic [7:0]  rmem [1024];
    logic [3:0]  cap_wb [2];
    logic [7:0]  cap_addr [2];
    logic [31:0] cap_wd [2];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input int a, input int sz, input logic u);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(rmem[(a + i) % 1024]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic xfer(input logic w, input logic [1:0] sz, input logic u, input logic [9:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] data,
                        output logic err, output int strb);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check32("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin cap_wb[k] = 4'd0; cap_addr[k] = 8'd0; cap_wd[k] = 32'd0; end
        lat = 1;
        strb = 0;
        cap_wb[0] = dmem_writeb; cap_addr[0] = dmem_addr; cap_wd[0] = dmem_wdata;
        if (dmem_read || dmem_writeb != 4'd0) strb++;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin cap_wb[1] = dmem_writeb; cap_addr[1] = dmem_addr; cap_wd[1] = dmem_wdata; end
            if (dmem_read || dmem_writeb != 4'd0) strb++;
        end
        data = resp_data;
        err  = resp_err;
    endtask

    task automatic run_op(input logic w, input logic [1:0] sz, input logic u, input logic [9:0] a,
                          input logic [31:0] wd, input string tag);
        int ai, n, exp_lat, exp_strb, lat, strb;
        logic cr, ill, err;
        logic [31:0] exp_data, data;
        ai  = int'(a);
        n   = 1 << sz;
        cr  = ((ai % 4) + n) > 4;
        ill = (sz == 2'd3) || (cr && !SPLIT);
        exp_data = (ill || w) ? 32'd0 : model_load(ai, int'(sz), u);
        exp_lat  = ill ? 2 : (w ? (cr ? 3 : 2) : (cr ? 4 : 3));
        exp_strb = ill ? 0 : (cr ? 2 : 1);
        xfer(w, sz, u, a, wd, lat, data, err, strb);
        check32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check32({tag, "_data"}, data, exp_data);
        check32({tag, "_err"}, 32'(err), 32'(ill));
        check32({tag, "_strobes"}, 32'(strb), 32'(exp_strb));
        if (w && !ill)
            for (int i = 0; i < n; i++) rmem[(ai + i) % 1024] = 8'(wd >> (8 * i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check32({tag, "_resp_data"}, resp_data, 32'd0);
        check32({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check32({tag, "_dmem_read"}, 32'(dmem_read), 32'd0);
        check32({tag, "_dmem_writeb"}, 32'(dmem_writeb), 32'd0);
        check32({tag, "_dmem_addr"}, 32'(dmem_addr), 32'd0);
        check32({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
        check32({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 10'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Preload words 0..15 and 250..255 through the unit.
        for (int i = 0; i < 16; i++) run_op(1'b1, 2'd2, 1'b0, 10'(4 * i), $urandom, "init_lo");
        for (int i = 250; i < 256; i++) run_op(1'b1, 2'd2, 1'b0, 10'(4 * i), $urandom, "init_hi");

        // Reset asserted in the middle of an ACC0 store cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 10'h000; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        check32("acc0_store_wb", 32'(dmem_writeb), 32'hF);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_acc0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 2'd2, 1'b0, 10'h000, 32'd0, "post_reset_load");

        run_op(1'b1, 2'd2, 1'b0, 10'h004, 32'hDEADBEEF, "st_word");
        check32("st_word_wb", 32'(cap_wb[0]), 32'hF);
        check32("st_word_addr", 32'(cap_addr[0]), 32'd1);
        run_op(1'b0, 2'd0, 1'b0, 10'h007, 32'd0, "ld_sbyte");
        check32("ld_sbyte_value", model_load(7, 0, 1'b0), 32'hFFFFFFDE);

        run_op(1'b1, 2'd1, 1'b0, 10'h00A, 32'h00001234, "st_half");
        check32("st_half_wb", 32'(cap_wb[0]), 32'hC);
        check32("st_half_wdata_hi", 32'(cap_wd[0][31:16]), 32'h1234);
        run_op(1'b0, 2'd1, 1'b1, 10'h00A, 32'd0, "ld_uhalf");

        if (SPLIT) begin
            run_op(1'b1, 2'd2, 1'b0, 10'h3FE, 32'hA1B2C3D4, "split_st");
            check32("split_st_wb0", 32'(cap_wb[0]), 32'hC);
            check32("split_st_addr0", 32'(cap_addr[0]), 32'd255);
            check32("split_st_wd0", 32'(cap_wd[0][31:16]), 32'hC3D4);
            check32("split_st_wb1", 32'(cap_wb[1]), 32'h3);
            check32("split_st_addr1", 32'(cap_addr[1]), 32'd0);
            check32("split_st_wd1", 32'(cap_wd[1][15:0]), 32'hA1B2);
            run_op(1'b0, 2'd2, 1'b0, 10'h3FE, 32'd0, "split_ld");
        end else begin
            run_op(1'b0, 2'd2, 1'b0, 10'h001, 32'd0, "cross_err");
        end

        // Illegal size with req_valid held high into the next request.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 10'h010;
        @(posedge clk);
        @(negedge clk);
        check32("sz3_c1_read", 32'(dmem_read), 32'd0);
        check32("sz3_c1_wb", 32'(dmem_writeb), 32'd0);
        req_size = 2'd2;
        @(negedge clk);
        check32("sz3_c2_valid", 32'(resp_valid), 32'd1);
        check32("sz3_c2_err", 32'(resp_err), 32'd1);
        check32("sz3_c2_data", resp_data, 32'd0);
        check32("sz3_c2_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        check32("chained_lat", 32'(lat), 32'd3);
        check32("chained_data", resp_data, model_load(16, 2, 1'b0));
        check32("chained_err", 32'(resp_err), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [9:0] a;
            a = ($urandom % 2 == 0) ? 10'($urandom_range(59, 0)) : 10'($urandom_range(1023, 1000));
            run_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rand");
        end

        @(negedge clk);
        check32("no_repeat_strobe", 32'(repeat_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
